// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 Hz raster timing constants shared by all graphics layers
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int CNT_W = 10;

  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_pix_tick_div.sv
// rtl/vga_sync_gen_pix_tick_div.sv - pixel-enable divider, one p_tick every CLK_DIV clocks
module pix_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  // With CLK_DIV=1 the counter is pinned at 0 and p_tick stays high.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters with zero-skew registered sync, video_on and frame_tick
module vga_sync_gen #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK    = vga_timing_pkg::H_BACK,
  parameter int   V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_tick
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_MAX = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);

  logic       tick;
  logic       h_wrap, v_wrap;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hsync_q, vsync_q, video_on_q, frame_tick_q;

  pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .p_tick(tick)
  );

  always_comb begin
    h_wrap = tick && (h_q == H_MAX);
    v_wrap = h_wrap && (v_q == V_MAX);
    h_d    = h_q;
    v_d    = v_q;
    if (tick) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
    end
    if (h_wrap) begin
      v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
    end
  end

  // Decode from next-state counters so the registered flags line up with pix_x/pix_y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q          <= '0;
      v_q          <= '0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= in_window(h_d, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync_q      <= in_window(v_d, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      video_on_q   <= (h_d < H_VIS) && (v_d < V_VIS);
      frame_tick_q <= v_wrap;
    end
  end

  assign p_tick     = tick;
  assign pix_x      = h_q;
  assign pix_y      = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench: default, CLK_DIV=1/active-high and shrunken-timing instances
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       ft;
  } exp_t;

  typedef struct {
    int   n;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_def = 1'b0, rst_fast = 1'b0, rst_small = 1'b0;

  logic       d_hs, d_vs, d_von, d_pt, d_ft;
  logic [9:0] d_x, d_y;
  logic       f_hs, f_vs, f_von, f_pt, f_ft;
  logic [9:0] f_x, f_y;
  logic       s_hs, s_vs, s_von, s_pt, s_ft;
  logic [9:0] s_x, s_y;

  int vectors = 0;
  int miscompares = 0;
  int chk_viol = 0;
  int fast_hs_hi = 0, fast_pt_lo = 0, small_ft = 0, small_vs_lo = 0;

  exp_t sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  vga_sync_gen u_def (
    .clk(clk), .reset(rst_def), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .p_tick(d_pt), .pix_x(d_x), .pix_y(d_y), .frame_tick(d_ft)
  );

  vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_fast (
    .clk(clk), .reset(rst_fast), .hsync(f_hs), .vsync(f_vs), .video_on(f_von),
    .p_tick(f_pt), .pix_x(f_x), .pix_y(f_y), .frame_tick(f_ft)
  );

  vga_sync_gen #(.CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                 .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_small (
    .clk(clk), .reset(rst_small), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .p_tick(s_pt), .pix_x(s_x), .pix_y(s_y), .frame_tick(s_ft)
  );

  function automatic exp_t model_gen(int n, int d, int hd, int hf, int hsw, int hb,
                                     int vd, int vf, int vsw, int vb, bit pol);
    exp_t e;
    int ht, vt, habs, h, v;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    if (n == 0) begin
      e = '{x: 10'd0, y: 10'd0, hs: ~pol, vs: ~pol, von: 1'b0, pt: (d == 1), ft: 1'b0};
      return e;
    end
    habs  = n / d;
    h     = habs % ht;
    v     = (habs / ht) % vt;
    e.x   = 10'(h);
    e.y   = 10'(v);
    e.hs  = (h >= hd + hf && h <= hd + hf + hsw - 1) ? pol : ~pol;
    e.vs  = (v >= vd + vf && v <= vd + vf + vsw - 1) ? pol : ~pol;
    e.von = (h < hd) && (v < vd);
    e.pt  = (n % d) == d - 1;
    e.ft  = (n % (d * ht * vt)) == 0;
    return e;
  endfunction

  function automatic exp_t model(int sel, int n);
    case (sel)
      0:       return model_gen(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      1:       return model_gen(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
      default: return model_gen(n, 2, 8, 2, 3, 3, 6, 2, 2, 3, 1'b0);
    endcase
  endfunction

  function automatic exp_t obs(int sel);
    case (sel)
      0:       return {d_x, d_y, d_hs, d_vs, d_von, d_pt, d_ft};
      1:       return {f_x, f_y, f_hs, f_vs, f_von, f_pt, f_ft};
      default: return {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_ft};
    endcase
  endfunction

  function automatic vec_t mk(int n, int x, int y, bit hs, bit vs, bit von, bit pt, bit ft);
    vec_t r;
    r.n = n;
    r.e = '{x: 10'(x), y: 10'(y), hs: hs, vs: vs, von: von, pt: pt, ft: ft};
    return r;
  endfunction

  task automatic check_vec(string tag, int n, exp_t a, exp_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s n=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b want x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b",
               tag, n, a.x, a.y, a.hs, a.vs, a.von, a.pt, a.ft,
               e.x, e.y, e.hs, e.vs, e.von, e.pt, e.ft);
    end
  endtask

  task automatic check_int(string tag, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check_now(int sel, string tag, exp_t e);
    exp_t w;
    sb_q.push_back(e);
    w = sb_q.pop_front();
    check_vec(tag, 0, obs(sel), w);
  endtask

  task automatic run(int sel, string tag, int n_from, int n_to);
    exp_t a, e;
    for (int n = n_from; n <= n_to; n++) begin
      sb_q.push_back(model(sel, n));
      @(negedge clk);
      a = obs(sel);
      e = sb_q.pop_front();
      check_vec(tag, n, a, e);
      if (sel == 1 && n <= 800 && a.hs) fast_hs_hi++;
      if (sel == 1 && !a.pt) fast_pt_lo++;
      if (sel == 2 && n <= 832 && a.ft) small_ft++;
      if (sel == 2 && n <= 416 && !a.vs) small_vs_lo++;
    end
  endtask

  // Invariants over every instance, every cycle.
  always @(negedge clk) begin
    if (d_x > 10'd799 || d_y > 10'd524 || (d_von && (!d_hs || !d_vs))) chk_viol++;
    if (f_x > 10'd799 || f_y > 10'd524 || (f_von && (f_hs || f_vs))) chk_viol++;
    if (s_x > 10'd15 || s_y > 10'd12 || (s_von && (!s_hs || !s_vs))) chk_viol++;
  end

  initial begin
    exp_t a, e;
    int   k, hs_low, first_x, last_x, von_clks, def_ft;

    tbl.push_back(mk(1,    0,   0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(3,    0,   0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(4,    1,   0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(2559, 639, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(2560, 640, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(2623, 655, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(2624, 656, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3007, 751, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(3008, 752, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(3196, 799, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(3199, 799, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(3200, 0,   1, 1, 1, 1, 0, 0));

    repeat (3) @(negedge clk);
    check_now(0, "def_reset",   mk(0, 0, 0, 1, 1, 0, 0, 0).e);
    check_now(1, "fast_reset",  model(1, 0));
    check_now(2, "small_reset", model(2, 0));

    rst_def  = 1'b1;
    k        = 0;
    hs_low   = 0;
    first_x  = -1;
    last_x   = -1;
    von_clks = 0;
    def_ft   = 0;
    for (int n = 1; n <= 6400; n++) begin
      if (k < tbl.size() && tbl[k].n == n) sb_q.push_back(tbl[k].e);
      @(negedge clk);
      a = obs(0);
      if (k < tbl.size() && tbl[k].n == n) begin
        e = sb_q.pop_front();
        check_vec("def_tbl", n, a, e);
        k++;
      end
      if (n <= 3200) begin
        if (!a.hs) begin
          hs_low++;
          if (first_x < 0) first_x = int'(a.x);
          last_x = int'(a.x);
        end
        if (a.von) von_clks++;
      end
      if (a.ft) def_ft++;
    end
    check_int("def_hsync_low_clks", hs_low, 384);
    check_int("def_hsync_first_x", first_x, 656);
    check_int("def_hsync_last_x", last_x, 751);
    check_int("def_video_on_clks", von_clks, 2560);
    check_int("def_no_frame_tick", def_ft, 0);

    rst_fast = 1'b1;
    run(1, "fast", 1, 1600);
    check_int("fast_hsync_high_clks", fast_hs_hi, 96);
    check_int("fast_ptick_low_clks", fast_pt_lo, 0);

    rst_small = 1'b1;
    run(2, "small", 1, 900);
    check_int("small_frame_ticks", small_ft, 2);
    check_int("small_vsync_low_clks", small_vs_lo, 64);

    #2 rst_small = 1'b0;
    #1 check_now(2, "small_async_reset", model(2, 0));
    @(negedge clk);
    check_now(2, "small_held_reset", model(2, 0));
    rst_small = 1'b1;
    run(2, "small_restart", 1, 100);

    check_int("checker_violations", chk_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
